// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory read port, redirect input and decode handshake.
interface instr_fetch_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [15:0] instr_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_rvalid,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_rvalid,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch: issues one memory read, holds the word for decode,
// and squashes in-flight responses when a redirect arrives.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'h0001
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]  state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic        squash_reg, squash_next;
  logic        valid_reg, valid_next;
  logic [31:0] instr_reg, instr_next;
  logic [15:0] ipc_reg, ipc_next;

  // A redirect in REQ suppresses the request so the stale pc never reaches memory.
  assign bus.imem_req    = (state_reg == REQ) && !bus.redirect_valid;
  assign bus.imem_addr   = pc_reg;
  assign bus.instr_valid = valid_reg;
  assign bus.instr       = instr_reg;
  assign bus.instr_pc    = ipc_reg;

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    squash_next = squash_reg;
    valid_next  = valid_reg;
    instr_next  = instr_reg;
    ipc_next    = ipc_reg;
    case (state_reg)
      IDLE: state_next = REQ;
      REQ: begin
        if (bus.redirect_valid) begin
          pc_next = bus.redirect_pc;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.redirect_valid) begin
          pc_next = bus.redirect_pc;
          // Without a response this cycle the request is still in flight; mark it stale.
          if (bus.imem_rvalid) begin
            squash_next = 1'b0;
            state_next  = REQ;
          end else begin
            squash_next = 1'b1;
          end
        end else if (bus.imem_rvalid) begin
          if (squash_reg) begin
            squash_next = 1'b0;
            state_next  = REQ;
          end else begin
            instr_next = bus.imem_rdata;
            ipc_next   = pc_reg;
            valid_next = 1'b1;
            pc_next    = pc_reg + PC_STEP;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          pc_next    = bus.redirect_pc;
          valid_next = 1'b0;
          state_next = REQ;
        end else if (bus.instr_ready) begin
          valid_next = 1'b0;
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      squash_reg <= 1'b0;
      valid_reg  <= 1'b0;
      instr_reg  <= 32'h0;
      ipc_reg    <= 16'h0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      squash_reg <= squash_next;
      valid_reg  <= valid_next;
      instr_reg  <= instr_next;
      ipc_reg    <= ipc_next;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle-by-cycle scenarios against a latency-programmable memory.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if bus ();
  instr_fetch_if bus2 ();

  instr_fetch_unit #(.RESET_PC(16'h0000), .PC_STEP(16'h0001)) dut (.clk(clk), .rst(rst), .bus(bus));
  instr_fetch_unit #(.RESET_PC(16'hFFFF), .PC_STEP(16'h0001)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_checks = 0;
  int n_fail   = 0;

  // Memory for dut: word at address a is {6'b000100, 10'h0, a}; latency set per scenario.
  int          mem_lat = 1;
  logic        m_pend  = 1'b0;
  int          m_cnt   = 0;
  logic [15:0] m_addr  = 16'h0;

  function automatic logic [31:0] memword(input logic [15:0] a);
    return {6'b000100, 10'h0, a};
  endfunction

  always @(posedge clk) begin
    bus.imem_rvalid <= 1'b0;
    if (bus.imem_req) begin
      m_pend = 1'b1;
      m_cnt  = mem_lat;
      m_addr = bus.imem_addr;
    end
    if (m_pend) begin
      if (m_cnt <= 1) begin
        bus.imem_rvalid <= 1'b1;
        bus.imem_rdata  <= memword(m_addr);
        m_pend = 1'b0;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.instr_valid && bus.instr_ready)
      $display("txn dut  pc=%h instr=%h", bus.instr_pc, bus.instr);
    if (!rst && bus2.instr_valid && bus2.instr_ready)
      $display("txn dut2 pc=%h instr=%h", bus2.instr_pc, bus2.instr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.redirect_valid = 1'b0; bus.redirect_pc = 16'h0; bus.instr_ready = 1'b1;
    bus2.redirect_valid = 1'b0; bus2.redirect_pc = 16'h0; bus2.instr_ready = 1'b1;
    bus2.imem_rvalid = 1'b0; bus2.imem_rdata = 32'h0;
    rst = 1'b1;
    step(); step();
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", bus.imem_req); end
    n_checks++; if (bus.imem_addr !== 16'h0) begin n_fail++; $display("FAIL rst_addr got %h exp 0000", bus.imem_addr); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", bus.instr_valid); end
    n_checks++; if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h exp 0", bus.instr); end
    n_checks++; if (bus.instr_pc !== 16'h0) begin n_fail++; $display("FAIL rst_ipc got %h exp 0", bus.instr_pc); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req got %b exp 0", bus.imem_req); end
  endtask

  task automatic test_basic();
    step();
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0) begin n_fail++; $display("FAIL first_req got req=%b addr=%h exp 1/0000", bus.imem_req, bus.imem_addr); end
    step();
    n_checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_quiet got req=%b valid=%b exp 0/0", bus.imem_req, bus.instr_valid); end
    step();
    n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0 || bus.instr !== 32'h1000_0000) begin n_fail++; $display("FAIL first_instr got v=%b pc=%h i=%h exp 1/0000/10000000", bus.instr_valid, bus.instr_pc, bus.instr); end
    step();
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h1 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL second_req got req=%b addr=%h v=%b exp 1/0001/0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
  endtask

  task automatic test_backpressure();
    bus.instr_ready = 1'b0;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h1000_0001 || bus.instr_pc !== 16'h1 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_%0d got v=%b i=%h pc=%h req=%b exp 1/10000001/0001/0", i, bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_req); end
      step();
    end
    bus.instr_ready = 1'b1;
    #1;
    n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL hold_release got v=%b exp 1", bus.instr_valid); end
    step();
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h2) begin n_fail++; $display("FAIL after_hold_req got req=%b addr=%h exp 1/0002", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_redirect_wait();
    mem_lat = 3;
    step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0040;
    #1;
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rw_req got %b exp 0", bus.imem_req); end
    step();
    bus.redirect_valid = 1'b0;
    #1;
    n_checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 16'h0040) begin n_fail++; $display("FAIL rw_squash got req=%b addr=%h exp 0/0040", bus.imem_req, bus.imem_addr); end
    step();
    step();
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0040 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rw_refetch got req=%b addr=%h v=%b exp 1/0040/0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
    step(); step(); step(); step();
    n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0040 || bus.instr !== 32'h1000_0040) begin n_fail++; $display("FAIL rw_deliver got v=%b pc=%h i=%h exp 1/0040/10000040", bus.instr_valid, bus.instr_pc, bus.instr); end
    step();
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0041) begin n_fail++; $display("FAIL rw_next got req=%b addr=%h exp 1/0041", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_redirect_flush();
    mem_lat = 1;
    step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0080;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    n_checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0080) begin n_fail++; $display("FAIL rv_coincide got v=%b req=%b addr=%h exp 0/1/0080", bus.instr_valid, bus.imem_req, bus.imem_addr); end
    step(); step();
    n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0080) begin n_fail++; $display("FAIL rv_deliver got v=%b pc=%h exp 1/0080", bus.instr_valid, bus.instr_pc); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0010;
    step();
    bus.redirect_pc = 16'h0020;
    #1;
    n_checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.imem_addr !== 16'h0010) begin n_fail++; $display("FAIL hold_flush got v=%b req=%b addr=%h exp 0/0/0010", bus.instr_valid, bus.imem_req, bus.imem_addr); end
    step();
    bus.redirect_valid = 1'b0;
    #1;
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0020) begin n_fail++; $display("FAIL req_redirect got req=%b addr=%h exp 1/0020", bus.imem_req, bus.imem_addr); end
    step(); step();
    n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0020 || bus.instr !== 32'h1000_0020) begin n_fail++; $display("FAIL req_redirect_deliver got v=%b pc=%h i=%h exp 1/0020/10000020", bus.instr_valid, bus.instr_pc, bus.instr); end
  endtask

  task automatic test_latest_redirect();
    mem_lat = 3;
    step();
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0021) begin n_fail++; $display("FAIL lr_req got req=%b addr=%h exp 1/0021", bus.imem_req, bus.imem_addr); end
    step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0050;
    step();
    bus.redirect_pc = 16'h0060;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL lr_drop got v=%b exp 0", bus.instr_valid); end
    step();
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0060 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL lr_latest got req=%b addr=%h v=%b exp 1/0060/0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
  endtask

  task automatic test_async_reset();
    step();
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.imem_addr !== 16'h0 || bus.instr !== 32'h0 || bus.instr_pc !== 16'h0 || bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL async_rst got addr=%h i=%h pc=%h v=%b req=%b exp all 0", bus.imem_addr, bus.instr, bus.instr_pc, bus.instr_valid, bus.imem_req); end
    step();
    rst = 1'b0;
    step();
    n_checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0) begin n_fail++; $display("FAIL late_rvalid got v=%b req=%b addr=%h exp 0/1/0000", bus.instr_valid, bus.imem_req, bus.imem_addr); end
    step();
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL late_wait1 got v=%b exp 0", bus.instr_valid); end
    step();
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL late_wait2 got v=%b exp 0", bus.instr_valid); end
    step(); step();
    n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0 || bus.instr !== 32'h1000_0000) begin n_fail++; $display("FAIL post_rst_fetch got v=%b pc=%h i=%h exp 1/0000/10000000", bus.instr_valid, bus.instr_pc, bus.instr); end
  endtask

  task automatic test_pc_wrap();
    bus2.imem_rvalid = 1'b1; bus2.imem_rdata = 32'hAAAA_0001;
    step();
    bus2.imem_rvalid = 1'b0;
    #1;
    n_checks++; if (bus2.instr_valid !== 1'b1 || bus2.instr_pc !== 16'hFFFF || bus2.instr !== 32'hAAAA_0001) begin n_fail++; $display("FAIL wrap_first got v=%b pc=%h i=%h exp 1/ffff/aaaa0001", bus2.instr_valid, bus2.instr_pc, bus2.instr); end
    step();
    n_checks++; if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_addr got req=%b addr=%h exp 1/0000", bus2.imem_req, bus2.imem_addr); end
    step();
    bus2.imem_rvalid = 1'b1; bus2.imem_rdata = 32'hBBBB_0002;
    step();
    bus2.imem_rvalid = 1'b0;
    #1;
    n_checks++; if (bus2.instr_valid !== 1'b1 || bus2.instr_pc !== 16'h0000 || bus2.instr !== 32'hBBBB_0002) begin n_fail++; $display("FAIL wrap_second got v=%b pc=%h i=%h exp 1/0000/bbbb0002", bus2.instr_valid, bus2.instr_pc, bus2.instr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_flush();
    test_latest_redirect();
    test_async_reset();
    test_pc_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the PC loaded on reset.
REQ-002 Parameter PC_STEP, default 16'h0001, is the PC increment per accepted instruction; instruction memory is word-addressed.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 imem_req  output  1  read request to instruction memory, one-cycle pulse.
REQ-006 imem_addr  output  16  read address; valid while imem_req=1.
REQ-007 imem_rdata  input  32  instruction word returned by memory.
REQ-008 imem_rvalid  input  1  imem_rdata valid this cycle; latency >=1 cycle after imem_req.
REQ-009 redirect_valid  input  1  branch/jump redirect request.
REQ-010 redirect_pc  input  16  redirect target PC.
REQ-011 instr_valid  output  1  instr/instr_pc hold a valid instruction for decode.
REQ-012 instr_ready  input  1  decode accepts the instruction this cycle.
REQ-013 instr  output  32  fetched word; decode takes opcode from instr[31:26].
REQ-014 instr_pc  output  16  PC the word was fetched from.

Function
REQ-015 State machine SHALL have states IDLE, REQ, WAIT, HOLD; pc, a squash flag, and the output register are the only other state.
REQ-016 IDLE -> REQ unconditionally on the first clock edge after rst deasserts.
REQ-017 In REQ: imem_req=1 and imem_addr=pc, except imem_req=0 when redirect_valid=1; REQ -> WAIT when the request is issued.
REQ-018 At most one memory request SHALL be outstanding; imem_req SHALL be 0 in IDLE, WAIT, HOLD.
REQ-019 In WAIT, imem_rvalid with squash=0: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+PC_STEP, -> HOLD.
REQ-020 imem_rvalid outside WAIT SHALL be ignored.
REQ-021 In HOLD: instr, instr_pc, instr_valid stable until instr_valid&&instr_ready; on that cycle instr_valid<=0 and -> REQ.
REQ-022 Nominal throughput: one instruction per 3 cycles with 1-cycle memory latency and instr_ready=1.
REQ-023 PC arithmetic modulo 2^16: pc=16'hFFFF, PC_STEP=1 -> 16'h0000, no flag.
REQ-024 redirect_valid in any non-IDLE state SHALL: pc<=redirect_pc, instr_valid<=0 (flush, even if instr_ready=1 same cycle), -> REQ.
REQ-025 Exception: redirect in WAIT without imem_rvalid that cycle: pc<=redirect_pc, squash<=1, stay WAIT.
REQ-026 Redirect in WAIT coinciding with imem_rvalid: returned word discarded, squash stays 0, -> REQ.
REQ-027 In WAIT, imem_rvalid with squash=1: word discarded, squash<=0, pc unchanged, -> REQ.
REQ-028 Redirect with squash already 1 SHALL overwrite pc only; latest redirect wins.
REQ-029 Redirect in IDLE ignored.

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, pc=RESET_PC, squash=0, instr_valid=0, instr=0, instr_pc=0, imem_req=0, imem_addr=0 (when not in REQ, imem_addr=pc).
REQ-031 Reset mid-WAIT: a later imem_rvalid for the abandoned request arrives outside WAIT and is ignored per REQ-020.

Verification
REQ-032 Reset release, memory 1-cycle latency returning {6'b000100,26'h0} at addr 0, instr_ready=1 -> imem_req at cycle 1 with addr 0; instr_valid cycle 3, instr_pc=0; next imem_addr=1.
REQ-033 instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc constant, imem_req=0 throughout; ready=1 -> next request addr=pc+1.
REQ-034 Redirect to 16'h0040 in WAIT, memory latency 3 -> stale word dropped, next imem_addr=16'h0040, delivered instr_pc=16'h0040.
REQ-035 Redirect coincident with imem_rvalid and in HOLD with instr_ready=1 -> instr_valid=0 next cycle, no stale instruction delivered.
REQ-036 RESET_PC=16'hFFFF, two fetches -> instr_pc 16'hFFFF then 16'h0000.
REQ-037 rst asserted asynchronously mid-WAIT -> outputs reset before next edge; late imem_rvalid produces no instr_valid.
